// File: rtl/risc5_irq_pkg.sv
// -----------------------------------------------------------------------------
// risc5_irq_pkg
// Shared definitions for the RISC5 multi-channel interrupt controller:
//   - IO register addresses (io_adr decode)
//   - STATUS register field positions
//   - parameter limits and the channel-id width helper
// Optional build macro used by the controller: IRQ_SYNC_EN (see risc5_irq_ctrl).
// -----------------------------------------------------------------------------
package risc5_irq_pkg;

    // Parameter limits of the controller.
    localparam int IRQ_MAX_NIRQ = 32;
    localparam int IRQ_MAX_NEST = 8;

    // IO register map, selected by io_adr.
    typedef enum logic [1:0] {
        IRQ_ENABLE  = 2'd0,   // rw, one enable bit per channel
        IRQ_MODE    = 2'd1,   // rw, 1 = edge, 0 = level
        IRQ_PENDING = 2'd2,   // r, write-1-to-clear (edge channels only)
        IRQ_STATUS  = 2'd3    // r {depth, top id, int_req, gie}, write bit0 -> gie
    } irq_reg_e;

    // STATUS register layout.
    localparam int STAT_GIE_BIT   = 0;
    localparam int STAT_REQ_BIT   = 1;
    localparam int STAT_TOP_LSB   = 8;
    localparam int STAT_TOP_W     = 5;
    localparam int STAT_DEPTH_LSB = 16;
    localparam int STAT_DEPTH_W   = 4;

    // Width of a channel id; at least one bit so a single-channel build still
    // has a legal int_id port.
    function automatic int irq_id_width(input int nirq);
        return (nirq > 1) ? $clog2(nirq) : 1;
    endfunction

endpackage

// File: rtl/irq_prio_enc.sv
// -----------------------------------------------------------------------------
// irq_prio_enc
// Combinational fixed-priority encoder: reports the lowest set index of req.
// Ports:
//   req    in   N     request vector, bit 0 has the highest priority
//   valid  out  1     at least one request bit set
//   id     out  IDW   index of the lowest set bit, 0 when valid=0
// -----------------------------------------------------------------------------
module irq_prio_enc
    import risc5_irq_pkg::*;
#(
    parameter int N   = 8,
    parameter int IDW = irq_id_width(N)
) (
    input  logic [N-1:0]   req,
    output logic           valid,
    output logic [IDW-1:0] id
);

    // Scanning from the top down lets the last hit, i.e. the lowest index, win.
    always_comb begin
        // NOTE: every output gets a default before the loop so no path through
        // this block leaves a value held, which would infer a latch.
        valid = |req;
        id    = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                id = IDW'(i);
            end
        end
    end

endmodule

// File: rtl/risc5_irq_ctrl.sv
// -----------------------------------------------------------------------------
// risc5_irq_ctrl
// Multi-channel interrupt controller for the RISC5 core. Extends the core's
// single edge-triggered irq/intPnd/intMd scheme to NIRQ channels with a
// per-channel edge/level mode, enable mask, fixed priority (channel 0 highest)
// and preemptive nesting up to NEST levels tracked on an in-service stack.
//
// Parameters:
//   NIRQ  number of interrupt channels (1..32)
//   NEST  maximum in-service nesting depth (1..8)
//
// Ports:
//   clk      in   1     system clock, rising edge
//   rst      in   1     synchronous reset, active-high
//   irq      in   NIRQ  raw peripheral interrupt lines, active-high
//   int_req  out  1     interrupt request to the CPU
//   int_id   out  IDW   channel behind int_req, 0 while int_req=0
//   cpu_ack  in   1     pulse: CPU has taken the requested interrupt
//   cpu_rti  in   1     pulse: CPU executed RTI
//   io_adr   in   2     register select (ENABLE, MODE, PENDING, STATUS)
//   io_wr    in   1     register write strobe
//   io_rd    in   1     register read strobe
//   io_din   in   32    write data
//   io_dout  out  32    read data, combinational, 0 while io_rd=0
//
// Build option:
//   IRQ_SYNC_EN  when defined, irq passes a 2-flop synchroniser before edge
//                detection (two extra cycles of latency); use it for
//                asynchronous peripheral sources. Undefined: irq is used
//                directly, as in the original core.
// -----------------------------------------------------------------------------
module risc5_irq_ctrl
    import risc5_irq_pkg::*;
#(
    parameter  int NIRQ = 8,
    parameter  int NEST = 4,
    localparam int IDW  = irq_id_width(NIRQ)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NIRQ-1:0] irq,
    output logic            int_req,
    output logic [IDW-1:0]  int_id,
    input  logic            cpu_ack,
    input  logic            cpu_rti,
    input  logic [1:0]      io_adr,
    input  logic            io_wr,
    input  logic            io_rd,
    input  logic [31:0]     io_din,
    output logic [31:0]     io_dout
);

    // Depth counts 0..NEST inclusive.
    localparam int DW = $clog2(NEST + 1);

    logic [NIRQ-1:0] irq_s;      // sampled irq lines
    logic [NIRQ-1:0] irq_q;      // previous irq_s, for edge detection
    logic [NIRQ-1:0] pending;
    logic [NIRQ-1:0] enable;
    logic [NIRQ-1:0] mode;       // 1 = edge, 0 = level
    logic            gie;
    logic [DW-1:0]   depth;
    logic [IDW-1:0]  stack [NEST];

    logic [NIRQ-1:0] active;
    logic            best_vld;
    logic [IDW-1:0]  best_id;
    logic [IDW-1:0]  top_id;
    logic            preempt;
    logic            depth_full;
    logic            ack_take;
    logic            pop;
    logic [DW-1:0]   push_slot;
    logic [NIRQ-1:0] edge_set;
    logic [NIRQ-1:0] ack_clr;
    logic [NIRQ-1:0] w1c_clr;
    logic [NIRQ-1:0] pending_nxt;

    // Only the low NIRQ bits (and bit 0 for gie) of io_din are meaningful;
    // the remainder is folded here so the unused upper bits are accounted for.
    logic            unused_din;
    assign unused_din = ^io_din;

    // -------------------------------------------------------------------------
    // Input sampling
    // -------------------------------------------------------------------------
`ifdef IRQ_SYNC_EN
    logic [NIRQ-1:0] sync1;
    logic [NIRQ-1:0] sync2;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= irq;
            sync2 <= sync1;
        end
    end

    assign irq_s = sync2;
`else
    assign irq_s = irq;
`endif

    // -------------------------------------------------------------------------
    // Arbitration
    // -------------------------------------------------------------------------
    assign active = pending & enable;

    irq_prio_enc #(
        .N   (NIRQ),
        .IDW (IDW)
    ) u_prio_enc (
        .req   (active),
        .valid (best_vld),
        .id    (best_id)
    );

    // Channel currently in service; meaningful only while depth > 0.
    always_comb begin
        top_id = '0;
        for (int k = 0; k < NEST; k++) begin
            if (depth == DW'(k + 1)) begin
                top_id = stack[k];
            end
        end
    end

    // With nothing in service the current level is NIRQ, which every channel
    // beats, so the comparison only matters once the stack is non-empty.
    assign preempt    = (depth == '0) || (best_id < top_id);
    assign depth_full = (depth == DW'(NEST));
    assign int_req    = gie & best_vld & preempt & ~depth_full;
    assign int_id     = int_req ? best_id : '0;

    // -------------------------------------------------------------------------
    // Stack control. An ack with no request is ignored, an rti on an empty
    // stack is ignored. Ack and rti together pop first, then push into the
    // freed slot, so the top entry is replaced and depth is unchanged.
    // -------------------------------------------------------------------------
    assign ack_take  = cpu_ack & int_req;
    assign pop       = cpu_rti & (depth != '0);
    assign push_slot = pop ? (depth - DW'(1)) : depth;

    // -------------------------------------------------------------------------
    // Pending update. Edge channels: a new edge sets, ack/w1c clear, and a
    // set in the same cycle wins over either clear. Level channels simply
    // follow the sampled line.
    // -------------------------------------------------------------------------
    assign edge_set = irq_s & ~irq_q;
    assign ack_clr  = ack_take ? (NIRQ'(1) << int_id) : '0;
    assign w1c_clr  = (io_wr && (io_adr == IRQ_PENDING)) ? io_din[NIRQ-1:0] : '0;

    assign pending_nxt = ( mode & (edge_set | (pending & ~(ack_clr | w1c_clr))))
                       | (~mode & irq_s);

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the stack is small and its top entry is visible through
            // STATUS, so it is cleared on reset together with depth rather
            // than left holding stale ids.
            irq_q   <= '0;
            pending <= '0;
            enable  <= '0;
            mode    <= '0;
            gie     <= 1'b0;
            depth   <= '0;
            for (int k = 0; k < NEST; k++) begin
                stack[k] <= '0;
            end
        end else begin
            // NOTE: all state here uses non-blocking assignments so every
            // register samples the pre-edge values, independent of order.
            irq_q   <= irq_s;
            pending <= pending_nxt;

            // Hardware never changes ENABLE, MODE or gie, so software writes
            // always take effect.
            if (io_wr) begin
                case (io_adr)
                    IRQ_ENABLE: enable <= io_din[NIRQ-1:0];
                    IRQ_MODE:   mode   <= io_din[NIRQ-1:0];
                    IRQ_STATUS: gie    <= io_din[STAT_GIE_BIT];
                    default:    ;
                endcase
            end

            if (ack_take && !pop) begin
                depth <= depth + DW'(1);
            end else if (pop && !ack_take) begin
                depth <= depth - DW'(1);
            end

            for (int k = 0; k < NEST; k++) begin
                if (ack_take && (push_slot == DW'(k))) begin
                    stack[k] <= int_id;
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // IO read mux; unused bits read 0.
    // -------------------------------------------------------------------------
    always_comb begin
        io_dout = '0;
        if (io_rd) begin
            case (io_adr)
                IRQ_ENABLE:  io_dout = 32'(enable);
                IRQ_MODE:    io_dout = 32'(mode);
                IRQ_PENDING: io_dout = 32'(pending);
                IRQ_STATUS: begin
                    io_dout[STAT_DEPTH_LSB +: STAT_DEPTH_W] = STAT_DEPTH_W'(depth);
                    io_dout[STAT_TOP_LSB +: STAT_TOP_W]     = STAT_TOP_W'(top_id);
                    io_dout[STAT_REQ_BIT]                   = int_req;
                    io_dout[STAT_GIE_BIT]                   = gie;
                end
                default: io_dout = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_risc5_irq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_risc5_irq_ctrl
// Self-checking bench for risc5_irq_ctrl (NIRQ=8, NEST=4). A vector table
// drives the basic edge/ack/rti flow; hand-written sequences cover reset,
// preemption, the nesting limit, same-cycle interactions and write-1-to-clear.
// Works with and without IRQ_SYNC_EN (sampling latency is accounted for).
// -----------------------------------------------------------------------------
module tb_risc5_irq_ctrl;
    import risc5_irq_pkg::*;

    localparam int NIRQ = 8;
    localparam int NEST = 4;
    localparam int IDW  = 3;
`ifdef IRQ_SYNC_EN
    localparam int SYNC_LAT = 2;
`else
    localparam int SYNC_LAT = 0;
`endif

    logic            clk = 1'b0;
    logic            rst;
    logic [NIRQ-1:0] irq;
    logic            int_req;
    logic [IDW-1:0]  int_id;
    logic            cpu_ack;
    logic            cpu_rti;
    logic [1:0]      io_adr;
    logic            io_wr;
    logic            io_rd;
    logic [31:0]     io_din;
    logic [31:0]     io_dout;

    int n_checks = 0;
    int n_fail   = 0;

    risc5_irq_ctrl #(
        .NIRQ (NIRQ),
        .NEST (NEST)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .irq     (irq),
        .int_req (int_req),
        .int_id  (int_id),
        .cpu_ack (cpu_ack),
        .cpu_rti (cpu_rti),
        .io_adr  (io_adr),
        .io_wr   (io_wr),
        .io_rd   (io_rd),
        .io_din  (io_din),
        .io_dout (io_dout)
    );

    always #5 clk = ~clk;

    // Vector record: inputs held for one cycle, outputs checked just before
    // the closing clock edge.
    typedef struct {
        logic [7:0]  irq;
        logic        ack;
        logic        rti;
        logic        wr;
        logic        rd;
        logic [1:0]  adr;
        logic [31:0] din;
        logic        sync_wait;   // let the sampling pipeline drain afterwards
        logic        exp_req;
        logic [2:0]  exp_id;
        logic [31:0] exp_dout;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_strobes();
        cpu_ack = 1'b0;
        cpu_rti = 1'b0;
        io_wr   = 1'b0;
        io_rd   = 1'b0;
        io_adr  = 2'd0;
        io_din  = 32'd0;
    endtask

    task automatic io_write(input logic [1:0] adr, input logic [31:0] data);
        io_adr = adr;
        io_din = data;
        io_wr  = 1'b1;
        step();
        io_wr  = 1'b0;
        io_din = 32'd0;
    endtask

    task automatic io_check(input logic [1:0] adr, input logic [31:0] exp, input string name);
        io_adr = adr;
        io_rd  = 1'b1;
        #1;
        check(name, io_dout, exp);
        io_rd  = 1'b0;
    endtask

    task automatic req_check(input logic exp_req, input logic [2:0] exp_id, input string name);
        #1;
        check({name, "_req"}, 32'(int_req), 32'(exp_req));
        check({name, "_id"},  32'(int_id),  32'(exp_id));
    endtask

    // One-cycle pulse, then wait until it is registered as pending and
    // irq_q has settled back to 0 so a later edge can be seen again.
    task automatic pulse_irq(input logic [7:0] mask);
        irq = mask;
        step();
        irq = '0;
        repeat (SYNC_LAT + 1) step();
    endtask

    task automatic do_reset(input string name);
        rst = 1'b1;
        irq = 8'hFF;
        clear_strobes();
        repeat (2) step();
        req_check(1'b0, 3'd0, {name, "_rst"});
        io_check(IRQ_ENABLE,  32'h0, {name, "_rst_enable"});
        io_check(IRQ_MODE,    32'h0, {name, "_rst_mode"});
        io_check(IRQ_PENDING, 32'h0, {name, "_rst_pending"});
        io_check(IRQ_STATUS,  32'h0, {name, "_rst_status"});
        irq = '0;
        rst = 1'b0;
        step();
    endtask

    task automatic setup(input logic [7:0] en, input logic [7:0] md);
        io_write(IRQ_ENABLE, 32'(en));
        io_write(IRQ_MODE,   32'(md));
        io_write(IRQ_STATUS, 32'h1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int chs[4];
        int lat;
        logic found;

        // irq, ack, rti, wr, rd, adr, din, sync_wait, exp_req, exp_id, exp_dout
        vecs[0] = '{8'h00, 0, 0, 1, 0, 2'd1, 32'h4, 0, 0, 3'd0, 32'h0};          // MODE = 04
        vecs[1] = '{8'h00, 0, 0, 1, 0, 2'd0, 32'h4, 0, 0, 3'd0, 32'h0};          // ENABLE = 04
        vecs[2] = '{8'h00, 0, 0, 1, 0, 2'd3, 32'h1, 0, 0, 3'd0, 32'h0};          // gie = 1
        vecs[3] = '{8'h04, 0, 0, 0, 0, 2'd0, 32'h0, 1, 0, 3'd0, 32'h0};          // pulse irq[2]
        vecs[4] = '{8'h00, 0, 0, 0, 1, 2'd2, 32'h0, 0, 1, 3'd2, 32'h4};          // pending, request
        vecs[5] = '{8'h00, 1, 0, 0, 0, 2'd0, 32'h0, 0, 1, 3'd2, 32'h0};          // cpu_ack
        vecs[6] = '{8'h00, 0, 0, 0, 1, 2'd2, 32'h0, 0, 0, 3'd0, 32'h0};          // pending cleared
        vecs[7] = '{8'h00, 0, 0, 0, 1, 2'd3, 32'h0, 0, 0, 3'd0, 32'h0001_0201};  // depth 1, top 2
        vecs[8] = '{8'h00, 0, 1, 0, 1, 2'd3, 32'h0, 0, 0, 3'd0, 32'h0001_0201};  // cpu_rti
        vecs[9] = '{8'h00, 0, 0, 0, 1, 2'd3, 32'h0, 0, 0, 3'd0, 32'h0000_0001};  // back to depth 0

        rst = 1'b1;
        irq = '0;
        clear_strobes();

        // ---------------- reset with all lines high ----------------
        do_reset("init");

        // ---------------- table: edge request, ack, rti ----------------
        for (int i = 0; i < 10; i++) begin
            irq     = vecs[i].irq;
            cpu_ack = vecs[i].ack;
            cpu_rti = vecs[i].rti;
            io_wr   = vecs[i].wr;
            io_rd   = vecs[i].rd;
            io_adr  = vecs[i].adr;
            io_din  = vecs[i].din;
            #1;
            check($sformatf("vec%0d_req", i),  32'(int_req), 32'(vecs[i].exp_req));
            check($sformatf("vec%0d_id", i),   32'(int_id),  32'(vecs[i].exp_id));
            check($sformatf("vec%0d_dout", i), io_dout,      vecs[i].exp_dout);
            step();
            if (vecs[i].sync_wait) begin
                irq = '0;
                clear_strobes();
                repeat (SYNC_LAT) step();
            end
        end
        clear_strobes();
        irq = '0;

        // ---------------- preemption with level channels ----------------
        do_reset("pre");
        setup(8'hFF, 8'h00);
        irq = 8'h20;
        repeat (SYNC_LAT + 1) step();
        req_check(1'b1, 3'd5, "pre_ch5");
        cpu_ack = 1'b1;
        step();
        cpu_ack = 1'b0;
        req_check(1'b0, 3'd0, "pre_in_service5");
        irq = 8'h22;
        repeat (SYNC_LAT + 1) step();
        req_check(1'b1, 3'd1, "pre_ch1_preempts");
        irq = 8'h60;
        repeat (SYNC_LAT + 1) step();
        req_check(1'b0, 3'd0, "pre_ch6_blocked");
        irq = '0;

        // ---------------- nesting limit ----------------
        do_reset("nest");
        setup(8'hFF, 8'hFF);
        chs = '{7, 5, 3, 1};
        for (int j = 0; j < 4; j++) begin
            pulse_irq(8'(1 << chs[j]));
            req_check(1'b1, 3'(chs[j]), $sformatf("nest_ch%0d", chs[j]));
            cpu_ack = 1'b1;
            step();
            cpu_ack = 1'b0;
        end
        io_check(IRQ_STATUS, 32'h0004_0101, "nest_full_status");
        pulse_irq(8'h01);
        req_check(1'b0, 3'd0, "nest_full_blocks");
        repeat (3) step();
        req_check(1'b0, 3'd0, "nest_full_holds");
        cpu_rti = 1'b1;
        step();
        cpu_rti = 1'b0;
        req_check(1'b1, 3'd0, "nest_after_rti");
        io_check(IRQ_STATUS, 32'h0003_0303, "nest_after_rti_status");

        // ---------------- same-cycle interactions ----------------
        do_reset("same");
        setup(8'h06, 8'h06);
        pulse_irq(8'h04);
        req_check(1'b1, 3'd2, "same_ch2");
        irq = 8'h04;
        repeat (SYNC_LAT) step();
        cpu_ack = 1'b1;
        step();
        cpu_ack = 1'b0;
        irq = '0;
        io_check(IRQ_PENDING, 32'h04, "same_set_wins");
        io_check(IRQ_STATUS, 32'h0001_0201, "same_ack_status");
        pulse_irq(8'h02);
        req_check(1'b1, 3'd1, "same_ch1");
        cpu_ack = 1'b1;
        cpu_rti = 1'b1;
        step();
        clear_strobes();
        io_check(IRQ_STATUS, 32'h0001_0101, "same_ack_rti_status");
        cpu_rti = 1'b1;
        step();
        cpu_rti = 1'b0;
        io_check(IRQ_STATUS, 32'h0000_0003, "same_rti_to_empty");
        cpu_rti = 1'b1;
        step();
        cpu_rti = 1'b0;
        io_check(IRQ_STATUS, 32'h0000_0003, "same_rti_at_zero");
        req_check(1'b1, 3'd2, "same_rti_at_zero");

        // ---------------- write-1-to-clear and sampling latency ----------------
        do_reset("w1c");
        setup(8'h08, 8'h08);
        irq   = 8'h08;
        lat   = 0;
        found = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            if (!found) begin
                step();
                if (int_req) begin
                    found = 1'b1;
                    lat   = c;
                end
            end
        end
        check("w1c_latency", 32'(lat), 32'(1 + SYNC_LAT));
        irq = '0;
        step();
        io_check(IRQ_PENDING, 32'h08, "w1c_before");
        io_write(IRQ_PENDING, 32'h08);
        req_check(1'b0, 3'd0, "w1c_drop");
        io_check(IRQ_PENDING, 32'h00, "w1c_after");
        io_write(IRQ_ENABLE, 32'hFFFF_FFFF);
        io_check(IRQ_ENABLE, 32'h0000_00FF, "unused_bits");
        clear_strobes();
        #1;
        check("dout_idle", io_dout, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
